// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : MEM-stage data-memory access unit. Turns load/store control into
//            a req/ack bus transaction, steers store lanes, extracts loads.
// Options  : MISALIGN_TRAP_EN - trap misaligned h/hu/w accesses instead of
//            forcing the low address bits aligned.
// Revision : 1.0 - initial release
// ============================================================================
module mem_access_unit #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] alu_result_i,
  input  logic [DATA_WIDTH-1:0] rd_data2_i,
  input  logic [2:0]            funct3_i,
  input  logic                  MemRead_i,
  input  logic                  MemWrite_i,
  output logic                  dmem_req_o,
  output logic                  dmem_we_o,
  output logic [ADDR_WIDTH-1:0] dmem_addr_o,
  output logic [DATA_WIDTH-1:0] dmem_wdata_o,
  output logic [3:0]            dmem_be_o,
  input  logic [DATA_WIDTH-1:0] dmem_rdata_i,
  input  logic                  dmem_ack_i,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  stall_o,
  output logic                  bus_err_o,
  output logic                  misaligned_o
);

  localparam logic [7:0] c_TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  r_state, w_state_nxt;
  logic [7:0]              r_cnt;
  logic [1:0]              r_off;
  logic [2:0]              r_funct3;
  logic                    r_we;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [DATA_WIDTH-1:0]   r_wdata;
  logic [3:0]              r_be;
  logic [DATA_WIDTH-1:0]   r_mem_data;
  logic                    r_bus_err;
  logic                    r_misaligned;

  logic                    w_mem_op;
  logic                    w_is_byte;
  logic                    w_is_half;
  logic [1:0]              w_off;
  logic                    w_trap;
  logic                    w_timeout;
  logic [3:0]              w_be;
  logic [DATA_WIDTH-1:0]   w_wdata;
  logic [DATA_WIDTH-1:0]   w_load_val;

  assign w_mem_op  = MemRead_i | MemWrite_i;
  // 000/100 are byte, 001/101 are half; everything else (incl. reserved) is word
  assign w_is_byte = (funct3_i[1:0] == 2'b00);
  assign w_is_half = (funct3_i[1:0] == 2'b01);

`ifdef MISALIGN_TRAP_EN
  logic w_misaligned;
  assign w_misaligned = (w_is_half && alu_result_i[0]) ||
                        (!w_is_byte && !w_is_half && (alu_result_i[1:0] != 2'b00));
  assign w_off  = alu_result_i[1:0];
  assign w_trap = w_mem_op && w_misaligned;
`else
  assign w_off  = w_is_byte ? alu_result_i[1:0] :
                  w_is_half ? {alu_result_i[1], 1'b0} : 2'b00;
  assign w_trap = 1'b0;
`endif

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = rd_data2_i;
    if (w_is_byte) begin
      w_be    = 4'b0001 << w_off;
      w_wdata = {4{rd_data2_i[7:0]}};
    end else if (w_is_half) begin
      w_be    = 4'b0011 << {w_off[1], 1'b0};
      w_wdata = {2{rd_data2_i[15:0]}};
    end
  end

  // Lane offset and size were captured on entry to REQ, so extraction uses them
  always_comb begin
    w_load_val = dmem_rdata_i;
    case (r_funct3)
      3'b000: w_load_val = {{24{dmem_rdata_i[8*r_off+7]}}, dmem_rdata_i[8*r_off +: 8]};
      3'b100: w_load_val = {24'd0, dmem_rdata_i[8*r_off +: 8]};
      3'b001: w_load_val = r_off[1] ? {{16{dmem_rdata_i[31]}}, dmem_rdata_i[31:16]}
                                    : {{16{dmem_rdata_i[15]}}, dmem_rdata_i[15:0]};
      3'b101: w_load_val = r_off[1] ? {16'd0, dmem_rdata_i[31:16]}
                                    : {16'd0, dmem_rdata_i[15:0]};
      default: w_load_val = dmem_rdata_i;
    endcase
  end

  assign w_timeout = (r_cnt == c_TIMEOUT_LAST) && !dmem_ack_i;

  always_comb begin
    w_state_nxt = r_state;
    stall_o     = 1'b0;
    case (r_state)
      S_IDLE: begin
        stall_o = w_mem_op;
        if (w_trap)        w_state_nxt = S_RESP;
        else if (w_mem_op) w_state_nxt = S_REQ;
      end
      S_REQ: begin
        stall_o = 1'b1;
        if (dmem_ack_i || w_timeout) w_state_nxt = S_RESP;
      end
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 8'd0;
      r_off        <= 2'd0;
      r_funct3     <= 3'd0;
      r_we         <= 1'b0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_be         <= 4'd0;
      r_mem_data   <= '0;
      r_bus_err    <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_bus_err    <= 1'b0;
      r_misaligned <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_trap) begin
            r_misaligned <= 1'b1;
          end else if (w_mem_op) begin
            r_we     <= MemWrite_i;
            r_addr   <= {alu_result_i[ADDR_WIDTH-1:2], 2'b00};
            r_wdata  <= w_wdata;
            r_be     <= w_be;
            r_off    <= w_off;
            r_funct3 <= funct3_i;
            r_cnt    <= 8'd0;
          end
        end
        S_REQ: begin
          if (dmem_ack_i) begin
            r_cnt <= 8'd0;
            if (!r_we) r_mem_data <= w_load_val;
          end else if (w_timeout) begin
            r_cnt     <= 8'd0;
            r_bus_err <= 1'b1;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dmem_req_o   = (r_state == S_REQ);
  assign dmem_we_o    = r_we;
  assign dmem_addr_o  = r_addr;
  assign dmem_wdata_o = r_wdata;
  assign dmem_be_o    = r_be;
  assign mem_data_o   = r_mem_data;
  assign bus_err_o    = r_bus_err;
  assign misaligned_o = r_misaligned;

endmodule
`default_nettype wire
